instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction.
REQ-003 The block SHALL have these ports, one per line:
 CLK  in  1  rising-edge clock
 RESET  in  1  synchronous, active-high reset
 STALL  in  1  hazard unit: hold the IF/ID register and PC
 FLUSH  in  1  taken branch/jump from a later stage: redirect and squash
 BRANCH_TARGET  in  32  redirect address, sampled when FLUSH=1
 IMEM_READ  out  1  instruction memory read request
 IMEM_ADDRESS  out  32  registered fetch address
 IMEM_READDATA  in  32  fetched word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
 IMEM_BUSYWAIT  in  1  memory not ready
 INSTRUCTION  out  32  IF/ID instruction, feeds decode and immediate generation
 PC_OUT  out  32  IF/ID PC of INSTRUCTION
 PC_PLUS4_OUT  out  32  PC_OUT+4, modulo 2^32
 VALID_OUT  out  1  INSTRUCTION is a real fetched instruction
 MISALIGNED_FAULT  out  1  sticky misaligned-redirect flag

Function
REQ-004 The FSM SHALL have states BOOT, FETCH, DISCARD.
REQ-005 BOOT SHALL last exactly one cycle after RESET deasserts, with IMEM_READ=0, then go to FETCH.
REQ-006 In FETCH, IMEM_READ SHALL be 1 and IMEM_ADDRESS SHALL equal the fetch PC.
REQ-007 A completion is a rising edge in FETCH with IMEM_BUSYWAIT=0 and no FLUSH; the fetch PC SHALL advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-008 On a completion with STALL=0, INSTRUCTION, PC_OUT and PC_PLUS4_OUT SHALL load the word and its PC on the same edge, with VALID_OUT=1. Latency is 1 cycle from completion to IF/ID.
REQ-009 On a completion with STALL=1, the word and PC SHALL go to a one-entry hold buffer, and IMEM_READ SHALL drop to 0 until the buffer drains.
REQ-010 On the first edge with STALL=0, a full hold buffer SHALL load IF/ID and empty; fetching resumes on the next cycle.
REQ-011 While STALL=1 and FLUSH=0, IF/ID SHALL hold all its values.
REQ-012 On an edge with STALL=0 and no completion and an empty buffer, IF/ID SHALL load NOP_INSTR with VALID_OUT=0.
REQ-013 FLUSH SHALL take priority over STALL.
REQ-014 On FLUSH, IF/ID SHALL load NOP_INSTR with VALID_OUT=0, the hold buffer SHALL empty, and the fetch PC SHALL load BRANCH_TARGET.
REQ-015 On FLUSH with IMEM_BUSYWAIT=0, the FSM SHALL stay in FETCH and fetch the target in the next cycle.
REQ-016 On FLUSH with IMEM_BUSYWAIT=1, the FSM SHALL go to DISCARD.
REQ-017 In DISCARD, IMEM_READ SHALL stay 1 and IMEM_ADDRESS SHALL keep the old address until IMEM_BUSYWAIT=0.
REQ-018 The word completed in DISCARD SHALL be dropped, and the FSM SHALL then return to FETCH at the target.
REQ-019 A further FLUSH during DISCARD SHALL overwrite the pending target; the last one wins.
REQ-020 IMEM_ADDRESS SHALL change only on edges where no read is outstanding with IMEM_BUSYWAIT=1.

Reset
REQ-021 While RESET=1 at a rising edge, the block SHALL reset to: state BOOT, fetch PC=RESET_PC, hold buffer empty, INSTRUCTION=NOP_INSTR, PC_OUT=0, PC_PLUS4_OUT=4, VALID_OUT=0, IMEM_READ=0, IMEM_ADDRESS=RESET_PC, MISALIGNED_FAULT=0.
REQ-022 RESET SHALL override FLUSH and STALL.
REQ-023 RESET during DISCARD or a busy read SHALL abandon the read; the block does not wait for the memory.

Configuration
REQ-024 With macro IF_MISALIGN_CHECK_EN defined, a FLUSH with BRANCH_TARGET[1:0]!=0 SHALL set MISALIGNED_FAULT (cleared only by RESET) and SHALL redirect to BRANCH_TARGET with bits[1:0] forced to 0.
REQ-025 With IF_MISALIGN_CHECK_EN undefined, MISALIGNED_FAULT SHALL be tied to 0 and BRANCH_TARGET[1:0] SHALL be ignored (treated as 0).

Structure
REQ-026 A shared package SHALL hold the FSM state typedef, NOP_INSTR and the PC width constant (32), for reuse by the decode and ID/EX stages.
REQ-027 The IF/ID register together with the hold buffer SHALL be one sub-module, ifid_register; the FSM and PC logic stay in the top.

Verification
REQ-028 Straight-line fetch: reset, IMEM_BUSYWAIT=0, memory returns address-tagged words -> PC_OUT goes 0,4,8,12 on consecutive cycles with VALID_OUT=1, starting 2 cycles after reset release.
REQ-029 Busy fetch: IMEM_BUSYWAIT=1 for 3 cycles at address 0x8 -> IMEM_ADDRESS holds 0x8, VALID_OUT=0 for 3 cycles, then the word for 0x8 appears with PC_OUT=0x8.
REQ-030 Stall during completion: STALL=1 for 4 cycles as word 0x10 completes -> IF/ID is frozen, IMEM_READ=0 after the capture, and 0x10 enters IF/ID on the first unstalled edge; none lost, none duplicated.
REQ-031 Flush during busy: FLUSH with target 0x100 while IMEM_BUSYWAIT=1 at 0x20 -> DISCARD entered, word for 0x20 never seen with VALID_OUT=1, next valid PC_OUT=0x100.
REQ-032 FLUSH and STALL together, target 0x40 -> IF/ID=NOP_INSTR with VALID_OUT=0, next valid PC_OUT=0x40.
REQ-033 Misaligned redirect (macro defined), target 0x202 -> MISALIGNED_FAULT=1 and stays 1, next fetch at 0x200; with the macro undefined, MISALIGNED_FAULT stays 0 and the fetch is at 0x200.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared IF-stage state type, bubble instruction and PC width.
package instruction_fetch_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, FETCH, DISCARD} if_state_t;
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(4);
  endfunction
endpackage

// File: rtl/instruction_fetch_ifid_register.sv
// ifid_register: IF/ID pipeline register plus one-entry hold buffer for words completed under stall.
module ifid_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            capture,
  input  logic [31:0]     word,
  input  logic [PC_W-1:0] word_pc,
  output logic [31:0]     instruction,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus4,
  output logic            valid,
  output logic            hold_full
);
  logic [31:0]     hold_word;
  logic [PC_W-1:0] hold_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_INSTR;
      pc_out      <= '0;
      valid       <= 1'b0;
      hold_full   <= 1'b0;
      hold_word   <= NOP_INSTR;
      hold_pc     <= '0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
      hold_full   <= 1'b0;
    end else if (stall) begin
      if (capture) begin
        hold_word <= word;
        hold_pc   <= word_pc;
        hold_full <= 1'b1;
      end
    end else if (hold_full) begin
      instruction <= hold_word;
      pc_out      <= hold_pc;
      valid       <= 1'b1;
      hold_full   <= 1'b0;
    end else if (capture) begin
      instruction <= word;
      pc_out      <= word_pc;
      valid       <= 1'b1;
    end else begin
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end
  end
  assign pc_plus4 = pc_inc(pc_out);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with BOOT/FETCH/DISCARD fetch FSM, PC and redirect handling.
// Optional IF_MISALIGN_CHECK_EN flags redirects whose target is not word aligned.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic [PC_W-1:0] BRANCH_TARGET,
  output logic            IMEM_READ,
  output logic [PC_W-1:0] IMEM_ADDRESS,
  input  logic [31:0]     IMEM_READDATA,
  input  logic            IMEM_BUSYWAIT,
  output logic [31:0]     INSTRUCTION,
  output logic [PC_W-1:0] PC_OUT,
  output logic [PC_W-1:0] PC_PLUS4_OUT,
  output logic            VALID_OUT,
  output logic            MISALIGNED_FAULT
);
  if_state_t       state, state_next;
  logic [PC_W-1:0] pc, pc_next, addr, addr_next, target;
  logic            hold_full, done, busy_read;
  assign target    = {BRANCH_TARGET[PC_W-1:2], 2'b00};
  assign IMEM_READ = (state == FETCH && !hold_full) || state == DISCARD;
  assign busy_read = IMEM_READ && IMEM_BUSYWAIT;
  assign done      = state == FETCH && IMEM_READ && !IMEM_BUSYWAIT && !FLUSH;
  // The address bus only moves once the outstanding read has completed.
  always_comb begin
    pc_next    = FLUSH ? target : done ? pc_inc(pc) : pc;
    state_next = busy_read ? (FLUSH ? DISCARD : state) : FETCH;
    addr_next  = state_next == DISCARD ? addr : pc_next;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= BOOT;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      addr  <= addr_next;
    end
  end
  assign IMEM_ADDRESS = addr;
`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RESET) MISALIGNED_FAULT <= 1'b0;
    else if (FLUSH && |BRANCH_TARGET[1:0]) MISALIGNED_FAULT <= 1'b1;
  end
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^BRANCH_TARGET[1:0];
  assign MISALIGNED_FAULT   = 1'b0;
`endif
  ifid_register #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk        (CLK),
    .rst        (RESET),
    .stall      (STALL),
    .flush      (FLUSH),
    .capture    (done),
    .word       (IMEM_READDATA),
    .word_pc    (addr),
    .instruction(INSTRUCTION),
    .pc_out     (PC_OUT),
    .pc_plus4   (PC_PLUS4_OUT),
    .valid      (VALID_OUT),
    .hold_full  (hold_full)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif
  logic        CLK = 1'b0, RESET = 1'b1, STALL = 1'b0, FLUSH = 1'b0, IMEM_BUSYWAIT = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        IMEM_READ, VALID_OUT, MISALIGNED_FAULT;
  logic [31:0] IMEM_ADDRESS, IMEM_READDATA, INSTRUCTION, PC_OUT, PC_PLUS4_OUT;
  int          errors = 0, checks = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign IMEM_READDATA = mem(IMEM_ADDRESS);

  instruction_fetch dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
    .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTRUCTION(INSTRUCTION),
    .PC_OUT(PC_OUT), .PC_PLUS4_OUT(PC_PLUS4_OUT), .VALID_OUT(VALID_OUT),
    .MISALIGNED_FAULT(MISALIGNED_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_valid(input string tag, input logic [31:0] pc);
    chk({tag, " valid"}, 32'(VALID_OUT), 32'd1);
    chk({tag, " pc"}, PC_OUT, pc);
    chk({tag, " pc4"}, PC_PLUS4_OUT, pc + 32'd4);
    chk({tag, " instr"}, INSTRUCTION, mem(pc));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, " valid"}, 32'(VALID_OUT), 32'd0);
    chk({tag, " instr"}, INSTRUCTION, NOP);
  endtask

  initial begin
    tick;
    chk("rst valid", 32'(VALID_OUT), 32'd0);
    chk("rst instr", INSTRUCTION, NOP);
    chk("rst pc", PC_OUT, 32'd0);
    chk("rst pc4", PC_PLUS4_OUT, 32'd4);
    chk("rst read", 32'(IMEM_READ), 32'd0);
    chk("rst addr", IMEM_ADDRESS, 32'd0);
    chk("rst fault", 32'(MISALIGNED_FAULT), 32'd0);
    RESET = 1'b0;
    tick;
    chk("boot read", 32'(IMEM_READ), 32'd1);
    chk("boot addr", IMEM_ADDRESS, 32'd0);
    chk_bubble("boot");
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_valid("straight", 32'(i * 4));
    end
    chk("straight addr", IMEM_ADDRESS, 32'h10);
    STALL = 1'b1;
    tick;
    chk("stall cap pc", PC_OUT, 32'hC);
    chk("stall cap valid", 32'(VALID_OUT), 32'd1);
    chk("stall cap read", 32'(IMEM_READ), 32'd0);
    chk("stall cap addr", IMEM_ADDRESS, 32'h14);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall hold pc", PC_OUT, 32'hC);
      chk("stall hold read", 32'(IMEM_READ), 32'd0);
    end
    STALL = 1'b0;
    tick;
    chk_valid("drain", 32'h10);
    chk("drain read", 32'(IMEM_READ), 32'd1);
    tick;
    chk_valid("after drain", 32'h14);
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    tick;
    tick;
    tick;
    chk("pre busy pc", PC_OUT, 32'h4);
    chk("pre busy addr", IMEM_ADDRESS, 32'h8);
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("busy addr", IMEM_ADDRESS, 32'h8);
      chk("busy read", 32'(IMEM_READ), 32'd1);
      chk_bubble("busy");
    end
    IMEM_BUSYWAIT = 1'b0;
    tick;
    chk_valid("busy done", 32'h8);
    for (int i = 0; i < 5; i++) tick;
    chk("pre flush addr", IMEM_ADDRESS, 32'h20);
    IMEM_BUSYWAIT = 1'b1;
    tick;
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'h100;
    tick;
    FLUSH = 1'b0;
    chk("discard addr", IMEM_ADDRESS, 32'h20);
    chk("discard read", 32'(IMEM_READ), 32'd1);
    chk_bubble("flush busy");
    tick;
    chk("discard hold addr", IMEM_ADDRESS, 32'h20);
    IMEM_BUSYWAIT = 1'b0;
    tick;
    chk_bubble("discard drop");
    chk("redirect addr", IMEM_ADDRESS, 32'h100);
    tick;
    chk_valid("target", 32'h100);
    IMEM_BUSYWAIT = 1'b1;
    tick;
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'h300;
    tick;
    BRANCH_TARGET = 32'h340;
    tick;
    chk("reflush addr", IMEM_ADDRESS, 32'h104);
    FLUSH = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    tick;
    chk("last flush wins", IMEM_ADDRESS, 32'h340);
    tick;
    chk_valid("last target", 32'h340);
    STALL = 1'b1;
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'h40;
    tick;
    chk_bubble("flush+stall");
    chk("flush+stall addr", IMEM_ADDRESS, 32'h40);
    STALL = 1'b0;
    FLUSH = 1'b0;
    tick;
    chk_valid("flush+stall target", 32'h40);
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'h202;
    tick;
    FLUSH = 1'b0;
    chk("misalign addr", IMEM_ADDRESS, 32'h200);
    chk("misalign fault", 32'(MISALIGNED_FAULT), 32'(EXP_MIS));
    tick;
    chk_valid("misalign target", 32'h200);
    tick;
    chk("misalign sticky", 32'(MISALIGNED_FAULT), 32'(EXP_MIS));
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'hFFFF_FFFC;
    tick;
    FLUSH = 1'b0;
    tick;
    chk_valid("wrap top", 32'hFFFF_FFFC);
    chk("wrap pc4", PC_PLUS4_OUT, 32'h0);
    chk("wrap addr", IMEM_ADDRESS, 32'h0);
    tick;
    chk_valid("wrap zero", 32'h0);
    IMEM_BUSYWAIT = 1'b1;
    tick;
    FLUSH = 1'b1;
    BRANCH_TARGET = 32'h500;
    tick;
    STALL = 1'b1;
    RESET = 1'b1;
    tick;
    chk("rst discard read", 32'(IMEM_READ), 32'd0);
    chk("rst discard addr", IMEM_ADDRESS, 32'h0);
    chk("rst discard fault", 32'(MISALIGNED_FAULT), 32'd0);
    chk_bubble("rst discard");
    RESET = 1'b0;
    STALL = 1'b0;
    FLUSH = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    tick;
    tick;
    chk_valid("post reset", 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
